// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter.
// The optional statistics block is enabled by MEM_PORT_ARBITER_STATS_EN.
package mem_port_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_e;

    localparam logic [2:0] FUNCT3_LW    = 3'b010;
    localparam int         STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of consecutive data grants taken while fetch was waiting.
// below_limit tells the arbiter whether data may still jump ahead of fetch.
module mem_port_arbiter_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic below_limit
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < LIMIT_C)) begin
            cnt_d = cnt_q + STARVE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign below_limit = (cnt_q < LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one access in flight.
// Define MEM_PORT_ARBITER_STATS_EN to add grant and wait-cycle counters.
//
//   state    | meaning
//   ARB_IDLE | no access outstanding; arbitrate and grant
//   ARB_BUSY | mem_req held with latched fields until mem_ack
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_PORT_ARBITER_STATS_EN
    ,
    output logic [31:0]       stat_if_grants,
    output logic [31:0]       stat_d_grants,
    output logic [31:0]       stat_wait_cycles
`endif
);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [2:0]        mem_funct3_q, mem_funct3_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic d_win;
    logic i_win;
    logic starve_below;

    mem_port_arbiter_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk         (clk),
        .rst         (rst),
        .inc         (d_win && if_req),
        .clr         ((d_win && !if_req) || i_win),
        .below_limit (starve_below)
    );

    always_comb begin
        d_win        = 1'b0;
        i_win        = 1'b0;
        state_d      = state_q;
        owner_d      = owner_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_funct3_d = mem_funct3_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rvalid_d  = 1'b0;
        d_rvalid_d   = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            ARB_IDLE: begin
                d_win = d_req && (!if_req || starve_below);
                i_win = !d_win && if_req;
                if (d_win) begin
                    state_d      = ARB_BUSY;
                    owner_d      = OWNER_D;
                    mem_req_d    = 1'b1;
                    mem_we_d     = d_we;
                    mem_funct3_d = d_funct3;
                    mem_addr_d   = d_addr;
                    mem_wdata_d  = d_wdata;
                end else if (i_win) begin
                    state_d      = ARB_BUSY;
                    owner_d      = OWNER_IF;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_funct3_d = FUNCT3_LW;
                    mem_addr_d   = if_addr;
                end
            end
            ARB_BUSY: begin
                if (mem_ack) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                    if (owner_q == OWNER_D) begin
                        d_rvalid_d = 1'b1;
                        // stores complete without touching the load data
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWNER_IF;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_funct3_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_funct3_q <= mem_funct3_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rvalid_q  <= if_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign if_gnt     = i_win;
    assign d_gnt      = d_win;
    assign if_rvalid  = if_rvalid_q;
    assign if_rdata   = if_rdata_q;
    assign d_rvalid   = d_rvalid_q;
    assign d_rdata    = d_rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_funct3 = mem_funct3_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

`ifdef MEM_PORT_ARBITER_STATS_EN
    logic [31:0] stat_if_q, stat_if_d;
    logic [31:0] stat_d_q, stat_d_d;
    logic [31:0] stat_wait_q, stat_wait_d;

    always_comb begin
        stat_if_d   = stat_if_q + {31'd0, i_win};
        stat_d_d    = stat_d_q + {31'd0, d_win};
        stat_wait_d = stat_wait_q + {31'd0, (if_req && !i_win) || (d_req && !d_win)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_if_q   <= '0;
            stat_d_q    <= '0;
            stat_wait_q <= '0;
        end else begin
            stat_if_q   <= stat_if_d;
            stat_d_q    <= stat_d_d;
            stat_wait_q <= stat_wait_d;
        end
    end

    assign stat_if_grants   = stat_if_q;
    assign stat_d_grants    = stat_d_q;
    assign stat_wait_cycles = stat_wait_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized requesters and memory checked against a transaction model.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [2:0]    d_funct3 = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [2:0]    mem_funct3;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
`ifdef MEM_PORT_ARBITER_STATS_EN
    logic [31:0]   s_if, s_d, s_w;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef MEM_PORT_ARBITER_STATS_EN
        , .stat_if_grants(s_if), .stat_d_grants(s_d), .stat_wait_cycles(s_w)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    // Transaction-level model: one outstanding access, owner, starvation count.
    bit          m_busy, m_owner_d, m_we, m_if_rv, m_d_rv, m_last_ig, m_last_dg;
    int          m_starve;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
    logic [2:0]  m_f3;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit exp_dg();
        return !m_busy && d_req && (!if_req || m_starve < LIM);
    endfunction

    function automatic bit exp_ig();
        return !m_busy && if_req && !exp_dg();
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner_d = 0; m_we = 0; m_if_rv = 0; m_d_rv = 0;
        m_last_ig = 0; m_last_dg = 0; m_starve = 0;
        m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0; m_f3 = '0;
    endtask

    task automatic model_step();
        bit dg, ig;
        dg = exp_dg();
        ig = exp_ig();
        m_last_dg = dg;
        m_last_ig = ig;
        m_if_rv = 0;
        m_d_rv  = 0;
        if (!m_busy) begin
            if (dg) begin
                m_busy = 1; m_owner_d = 1;
                m_we = d_we; m_f3 = d_funct3; m_addr = d_addr; m_wdata = d_wdata;
                m_starve = if_req ? ((m_starve + 1 > LIM) ? LIM : m_starve + 1) : 0;
            end else if (ig) begin
                m_busy = 1; m_owner_d = 0;
                m_we = 0; m_f3 = 3'b010; m_addr = if_addr;
                m_starve = 0;
            end
        end else if (mem_ack) begin
            m_busy = 0;
            if (m_owner_d) begin
                m_d_rv = 1;
                if (!m_we) m_d_rdata = mem_rdata;
            end else begin
                m_if_rv = 1;
                m_if_rdata = mem_rdata;
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("if_gnt", {31'd0, if_gnt}, {31'd0, exp_ig()});
            chk("d_gnt", {31'd0, d_gnt}, {31'd0, exp_dg()});
            chk("mem_req", {31'd0, mem_req}, {31'd0, m_busy});
            chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
            chk("mem_funct3", {29'd0, mem_funct3}, {29'd0, m_f3});
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, m_if_rv});
            chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, m_d_rv});
            chk("if_rdata", if_rdata, m_if_rdata);
            chk("d_rdata", d_rdata, m_d_rdata);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        if_req = 0; d_req = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ack = m_busy;
            cyc();
        end
        mem_ack = 0;
    endtask

    initial begin
        logic [5:0] order;
        int         ngr;

        model_reset();
        cyc(); cyc();
        chk_on = 1;
        #3;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        cyc();
        rst = 1;

        // fetch only
        if_req = 1; if_addr = 32'h10;
        #3;
        chk("t1_if_gnt", {31'd0, if_gnt}, 32'd1);
        chk("t1_d_gnt", {31'd0, d_gnt}, 32'd0);
        cyc();
        if_req = 0; if_addr = 32'hDEAD;
        #3;
        chk("t1_mem_req", {31'd0, mem_req}, 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h10);
        chk("t1_mem_funct3", {29'd0, mem_funct3}, 32'd2);
        mem_ack = 1; mem_rdata = 32'h00500093;
        cyc();
        mem_ack = 0;
        #3;
        chk("t1_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("t1_if_rdata", if_rdata, 32'h00500093);
        chk("t1_mem_req_off", {31'd0, mem_req}, 32'd0);
        cyc();
        #3;
        chk("t1_if_rvalid_end", {31'd0, if_rvalid}, 32'd0);

        // simultaneous requests: data first, fetch right after the data ack
        cyc();
        if_req = 1; if_addr = 32'h14;
        d_req = 1; d_we = 0; d_funct3 = 3'b010; d_addr = 32'h40;
        #3;
        chk("t2_d_gnt", {31'd0, d_gnt}, 32'd1);
        chk("t2_if_gnt", {31'd0, if_gnt}, 32'd0);
        cyc();
        d_req = 0;
        #3;
        chk("t2_mem_addr", mem_addr, 32'h40);
        mem_ack = 1; mem_rdata = 32'h1234;
        cyc();
        mem_ack = 0;
        #3;
        chk("t2_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("t2_d_rdata", d_rdata, 32'h1234);
        chk("t2_if_gnt_after", {31'd0, if_gnt}, 32'd1);
        cyc();
        if_req = 0;
        drain();

        // starvation: expected grant order D,D,D,D,IF,D
        d_req = 1; if_req = 1; d_we = 0; d_addr = 32'h100; if_addr = 32'h200;
        mem_rdata = 32'hCAFE0001;
        order = '0; ngr = 0;
        for (int i = 0; i < 40; i++) begin
            mem_ack = m_busy;
            #3;
            if (if_gnt || d_gnt) begin
                order = {order[4:0], d_gnt};
                ngr++;
            end
            if (ngr == 6) break;
            cyc();
        end
        chk("t3_grant_count", ngr, 32'd6);
        chk("t3_grant_order", {26'd0, order}, 32'b111101);
        cyc();
        drain();

        // store
        d_req = 1; d_we = 1; d_funct3 = 3'b000; d_addr = 32'h44; d_wdata = 32'hAB;
        #3;
        chk("t4_d_gnt", {31'd0, d_gnt}, 32'd1);
        cyc();
        d_req = 0; d_wdata = 32'h77;
        #3;
        chk("t4_mem_we", {31'd0, mem_we}, 32'd1);
        chk("t4_mem_wdata", mem_wdata, 32'hAB);
        chk("t4_mem_funct3", {29'd0, mem_funct3}, 32'd0);
        mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
        cyc();
        mem_ack = 0;
        #3;
        chk("t4_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("t4_d_rdata_kept", d_rdata, 32'hCAFE0001);
        cyc();

        // wait states
        d_req = 1; d_we = 0; d_funct3 = 3'b100; d_addr = 32'h80;
        if_req = 1; if_addr = 32'h300;
        #3;
        chk("t5_d_gnt", {31'd0, d_gnt}, 32'd1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("t5_hold_req", {31'd0, mem_req}, 32'd1);
            chk("t5_hold_addr", mem_addr, 32'h80);
            chk("t5_no_gnt", {31'd0, if_gnt | d_gnt}, 32'd0);
            cyc();
        end
        mem_ack = 1; mem_rdata = 32'h5A5A;
        cyc();
        mem_ack = 0; d_req = 0; if_req = 0;
        #3;
        chk("t5_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("t5_d_rdata", d_rdata, 32'h5A5A);
        cyc();
        #3;
        chk("t5_d_rvalid_once", {31'd0, d_rvalid}, 32'd0);
        cyc();

        // reset in BUSY, late ack afterwards is ignored
        if_req = 1; if_addr = 32'h400;
        cyc();
        if_req = 0;
        #3;
        chk("t6_busy", {31'd0, mem_req}, 32'd1);
        rst = 0;
        #1;
        chk("t6_async_clear", {31'd0, mem_req}, 32'd0);
        cyc();
        rst = 1; mem_ack = 1; if_req = 1; if_addr = 32'h404;
        #3;
        chk("t6_idle_gnt", {31'd0, if_gnt}, 32'd1);
        cyc();
        mem_ack = 0; if_req = 0;
        #3;
        chk("t6_no_rvalid", {31'd0, if_rvalid | d_rvalid}, 32'd0);
        chk("t6_new_addr", mem_addr, 32'h404);
        mem_ack = 1; mem_rdata = 32'h11;
        cyc();
        mem_ack = 0;
        #3;
        chk("t6_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("t6_if_rdata", if_rdata, 32'h11);
        cyc();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!if_req || m_last_ig) begin
                if_req  = ($urandom_range(0, 99) < 50);
                if_addr = $urandom & 32'hFFFF_FFFC;
            end else if ($urandom_range(0, 99) < 3) begin
                if_req = 0;
            end
            if (!d_req || m_last_dg) begin
                d_req    = ($urandom_range(0, 99) < 60);
                d_we     = $urandom_range(0, 1);
                d_funct3 = 3'($urandom_range(0, 7));
                d_addr   = $urandom;
                d_wdata  = $urandom;
            end else if ($urandom_range(0, 99) < 3) begin
                d_req = 0;
            end
            mem_ack   = m_busy ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 10);
            mem_rdata = $urandom;
            cyc();
        end
        drain();

        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between the IF stage (fetch requester) and the MEM stage (load/store requester).
- One memory transaction is outstanding at a time, using a req/ack handshake toward memory.
- Data accesses have priority; a starvation limit guarantees fetch progress.
- Replaces the ad-hoc EX/MEM-driven address muxing and NOP injection around the memory.

Parameters:
- ADDR_W, 32, width of all address buses
- DATA_W, 32, width of all data buses
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits; legal range 1..15

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_funct3  in  3  access size/sign (LB/LH/LW/LBU/LHU/SB/SH/SW)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data accepted this cycle (combinational)
- d_rvalid  out  1  one-cycle pulse: load data valid or store complete
- d_rdata  out  DATA_W  load data
- mem_req  out  1  registered request to memory
- mem_we  out  1  registered write enable
- mem_funct3  out  3  registered size field; forced 3'b010 on fetch
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_ack  in  1  memory completed the current access this cycle
- mem_rdata  in  DATA_W  read data; valid with mem_ack

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, owner=IF, starve_cnt=0.
  - mem_req, mem_we, if_rvalid, d_rvalid = 0; mem_funct3, mem_addr, mem_wdata, if_rdata, d_rdata = 0.
  - An in-flight access is abandoned; its ack is never reported.
- FSM states: IDLE, BUSY.
- IDLE arbitration, combinational each cycle:
  - Data wins when d_req && (!if_req || starve_cnt < STARVE_LIMIT).
  - Otherwise fetch wins when if_req.
  - The winner's gnt=1, the loser's gnt=0; gnt is 0 for both in BUSY.
- On a grant edge:
  - Latch addr, wdata, we and funct3 into the mem_* registers.
  - Set mem_req=1 and record the owner; go to BUSY.
- BUSY: mem_* outputs are held stable until mem_ack.
- On a mem_ack edge:
  - mem_req=0; the owner's rdata register loads mem_rdata.
  - The owner's rvalid is 1 for exactly the next cycle; go to IDLE.
- mem_ack is ignored in IDLE.
- Latency: grant at cycle N, earliest ack at N+1, rvalid at N+2; peak throughput is one access per 2 cycles.
- Simultaneous rvalid and a new grant are legal in the same IDLE cycle.
- starve_cnt:
  - Data grant with if_req=1: increments, saturating at STARVE_LIMIT.
  - Data grant with if_req=0: clears.
  - Fetch grant: clears.
- Stores also pulse d_rvalid; d_rdata is then unchanged.
- Request fields are sampled only at grant; changes after grant have no effect.
- A requester deasserting req before its grant is permitted and produces no access.

Optional Feature:
- Macro: MEM_PORT_ARBITER_STATS_EN.
- When defined, adds three output ports, each 32 bits, wrapping, reset to 0:
  - stat_if_grants: counts fetch grants.
  - stat_d_grants: counts data grants.
  - stat_wait_cycles: counts cycles where any req=1 and its gnt=0.
- When undefined, those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- defines.v gains:
  - ARB_IDLE / ARB_BUSY state encodings
  - OWNER_IF / OWNER_D encodings
  - the FUNCT3_LW constant used for fetch size
- One natural sub-module: arb_starve_ctr, a saturating counter with inc/clr/limit compare.
- All remaining logic stays in mem_port_arbiter.

Test Plan:
1. Reset, fetch only: if_req=1, if_addr=0x10; ack one cycle after mem_req with mem_rdata=0x00500093 → if_gnt at cycle 1, mem_addr=0x10, mem_funct3=010, if_rvalid pulse with if_rdata=0x00500093 two cycles after grant.
2. Simultaneous requests, starve_cnt=0: if_req=1 and d_req=1 (load 0x40) → d_gnt first, if_gnt=0; fetch is granted in the IDLE cycle after the data ack.
3. Starvation, STARVE_LIMIT=4: d_req and if_req held continuously → grant order D,D,D,D,IF,D,...; starve_cnt=4 then clears to 0.
4. Store: d_we=1, d_funct3=000, d_addr=0x44, d_wdata=0xAB → mem_we=1, mem_wdata=0xAB; d_rvalid pulse after ack, d_rdata unchanged.
5. Wait states: ack delayed 3 cycles → mem_req/mem_addr stable for all BUSY cycles, no new grant meanwhile; exactly one rvalid pulse.
6. Reset mid-BUSY: rst=0 while mem_req=1 → mem_req=0 immediately; after release, the late ack produces no rvalid and the state is IDLE.
